rpn_kip_to_network_bridge_merger: RTL and testbench
===================================================

// Module: rpn_kip_to_network_bridge_merger
// PURPOSE
// - Merges the two RPN KIP egress AXIS streams into the single AXIS stream to the network bridge.
//   - KIP TX side: PUB messages.
//   - KIP RX side: ACK messages.
// - Mirror of the from-network-bridge splitter.
// - Packet-atomic round-robin arbitration: a granted source keeps the output until its tlast beat is accepted.
// - Registered output stage; per-source packet counters for debug and status.
// PARAMETERS
// AXIS_DATA_WIDTH         64  tdata width (bits)
// AXIS_KEEP_WIDTH          8  tkeep width, = AXIS_DATA_WIDTH/8
// AXIS_TO_NB_TDEST_WIDTH  16  tid/tdest width
// AXIS_TO_NB_TUSER_WIDTH  16  tuser width
// CNT_WIDTH               32  packet counter width
// PORTS
// i_clk                          in   1      clock
// i_ap_rst                       in   1      synchronous active-high reset
// from_rpn_KIP_TX_t{valid,ready,data,keep,id,dest,user,last}  in/out(ready)  per params  source 0 (PUB)
// from_rpn_KIP_RX_t{valid,ready,data,keep,id,dest,user,last}  in/out(ready)  per params  source 1 (ACK)
// to_network_bridge_t{valid,ready,data,keep,id,dest,user,last} out/in(ready) per params  merged output
// o_tx_pkt_count                 out  CNT_WIDTH  tlast beats accepted from the TX source
// o_rx_pkt_count                 out  CNT_WIDTH  tlast beats accepted from the RX source
// BEHAVIOUR
// - Interface: one clock (i_clk); reset i_ap_rst is synchronous and active-high.
// - Reset values:
//   - to_network_bridge_tvalid=0; all output payload fields=0.
//   - Both source treadys=0; counters=0.
//   - FSM=IDLE; round-robin pointer rr=TX.
// - Output register: out_en = !to_nb_tvalid || to_nb_tready.
//   - Accepted source beat appears on the output the next cycle (latency 1).
//   - Payload is held stable while tvalid=1 and tready=0.
// - FSM states IDLE, LOCK_TX, LOCK_RX.
//   - In IDLE: both source treadys=0; no beat moves.
//   - IDLE, both valid: go to LOCK_<rr>.
//   - IDLE, one valid: go to LOCK of that source.
//   - IDLE, neither valid: stay IDLE.
//   - LOCK_x: from_x_tready = out_en; other source tready=0.
//   - Beat accepted when from_x_tvalid && from_x_tready: copied to the output register with all sideband fields unmodified.
//   - Accepted beat with tlast=1: go to IDLE and set rr = the other source.
//   - No beat from the other source may interleave within a packet.
// - Throughput:
//   - Each packet pays one IDLE arbitration cycle.
//   - Within a packet: 1 beat/cycle while downstream tready=1.
// - Counters: +1 on each accepted tlast beat of the respective source; wrap at 2^CNT_WIDTH.
// - Output tready drop mid-packet: the held output beat is unchanged; the source stalls (tready=0).
// - Source tvalid drop mid-packet: stay in LOCK_x; the output register drains normally.
// - Source deasserts tvalid in IDLE before arbitration: not granted. Sources obey AXIS and do not do this.
// - Reset mid-packet:
//   - The packet is truncated.
//   - Output tvalid=0 the cycle after reset is sampled.
//   - The downstream bridge discards the partial frame.
// - tkeep, tid, tdest and tuser are passed through, never checked or altered.
// TESTING
// - Reset check: assert i_ap_rst 2 cycles, all valids 1 -> tvalid=0, treadys=0, counters=0; first grant after reset goes to TX.
// - Single source, continuous ready:
//   - Stimulus: TX sends a 3-beat packet, tdata 0x11/0x22/0x33, downstream tready=1.
//   - Response: output beats 0x11, 0x22, 0x33(tlast) on consecutive cycles; o_tx_pkt_count=1.
// - Simultaneous contention:
//   - Stimulus: TX and RX each hold a 2-beat packet.
//   - Response: order TX,TX,RX,RX with no interleave; rr alternates. A second pair of packets also goes TX then RX.
// - Backpressure:
//   - Stimulus: downstream tready toggles 1010... during an RX 4-beat packet.
//   - Response: all 4 beats arrive in order, none duplicated or dropped; payload stable while stalled; o_rx_pkt_count=1.
// - Sideband passthrough: tid=0x5, tdest=0xABCD, tuser=0x1234, tkeep=0x0F -> identical values appear on the output beat.
// - Reset mid-packet + wrap:
//   - Reset after beat 2 of 4 -> FSM IDLE, output tvalid=0, and the next packet is output intact.
//   - With CNT_WIDTH=4, 17 TX packets -> o_tx_pkt_count=1.

Source files
------------

// File: rtl/rpn_kip_to_network_bridge_merger_if.sv
// AXI-Stream bundle shared by the KIP egress sources and the network-bridge output.
// Carries the full sideband set (tkeep, tid, tdest, tuser); tid and tdest share one width.
interface rpn_kip_to_network_bridge_merger_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [ID_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport master (
        output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/rpn_kip_to_network_bridge_merger.sv
// Merges the KIP TX (PUB) and KIP RX (ACK) AXIS streams into one network-bridge stream.
// Arbitration is packet-atomic round-robin, and the merged output is registered.
module rpn_kip_to_network_bridge_merger #(
    parameter int AXIS_DATA_WIDTH        = 64,
    parameter int AXIS_KEEP_WIDTH        = 8,
    parameter int AXIS_TO_NB_TDEST_WIDTH = 16,
    parameter int AXIS_TO_NB_TUSER_WIDTH = 16,
    parameter int CNT_WIDTH              = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_ap_rst,
    rpn_kip_to_network_bridge_merger_if.slave    from_rpn_kip_tx,
    rpn_kip_to_network_bridge_merger_if.slave    from_rpn_kip_rx,
    rpn_kip_to_network_bridge_merger_if.master   to_network_bridge,
    output logic [CNT_WIDTH-1:0]                 o_tx_pkt_count,
    output logic [CNT_WIDTH-1:0]                 o_rx_pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_TX = 2'd1,
        ST_LOCK_RX = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   rr_r;   // 1'b0: TX has priority on the next contention, 1'b1: RX

    logic out_en_s;
    logic tx_ready_s;
    logic rx_ready_s;
    logic tx_acc_s;
    logic rx_acc_s;

    logic                              out_valid_r;
    logic [AXIS_DATA_WIDTH-1:0]        out_data_r;
    logic [AXIS_KEEP_WIDTH-1:0]        out_keep_r;
    logic [AXIS_TO_NB_TDEST_WIDTH-1:0] out_id_r;
    logic [AXIS_TO_NB_TDEST_WIDTH-1:0] out_dest_r;
    logic [AXIS_TO_NB_TUSER_WIDTH-1:0] out_user_r;
    logic                              out_last_r;

    logic [AXIS_DATA_WIDTH-1:0]        mux_data_s;
    logic [AXIS_KEEP_WIDTH-1:0]        mux_keep_s;
    logic [AXIS_TO_NB_TDEST_WIDTH-1:0] mux_id_s;
    logic [AXIS_TO_NB_TDEST_WIDTH-1:0] mux_dest_s;
    logic [AXIS_TO_NB_TUSER_WIDTH-1:0] mux_user_s;
    logic                              mux_last_s;

    logic [CNT_WIDTH-1:0] tx_cnt_r;
    logic [CNT_WIDTH-1:0] rx_cnt_r;

    assign out_en_s = !out_valid_r || to_network_bridge.tready;
    assign tx_acc_s = from_rpn_kip_tx.tvalid && tx_ready_s;
    assign rx_acc_s = from_rpn_kip_rx.tvalid && rx_ready_s;

    assign from_rpn_kip_tx.tready  = tx_ready_s;
    assign from_rpn_kip_rx.tready  = rx_ready_s;
    assign to_network_bridge.tvalid = out_valid_r;
    assign to_network_bridge.tdata  = out_data_r;
    assign to_network_bridge.tkeep  = out_keep_r;
    assign to_network_bridge.tid    = out_id_r;
    assign to_network_bridge.tdest  = out_dest_r;
    assign to_network_bridge.tuser  = out_user_r;
    assign to_network_bridge.tlast  = out_last_r;
    assign o_tx_pkt_count = tx_cnt_r;
    assign o_rx_pkt_count = rx_cnt_r;

    // State register and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            state_r <= ST_IDLE;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (tx_acc_s && from_rpn_kip_tx.tlast) begin
                rr_r <= 1'b1;
            end else if (rx_acc_s && from_rpn_kip_rx.tlast) begin
                rr_r <= 1'b0;
            end
        end
    end

    // Grant selection and per-source ready; a lock is only released by an accepted tlast.
    always_comb begin
        state_nxt_s = state_r;
        tx_ready_s  = 1'b0;
        rx_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (from_rpn_kip_tx.tvalid && from_rpn_kip_rx.tvalid) begin
                    state_nxt_s = rr_r ? ST_LOCK_RX : ST_LOCK_TX;
                end else if (from_rpn_kip_tx.tvalid) begin
                    state_nxt_s = ST_LOCK_TX;
                end else if (from_rpn_kip_rx.tvalid) begin
                    state_nxt_s = ST_LOCK_RX;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK_TX: begin
                tx_ready_s = out_en_s;
                if (from_rpn_kip_tx.tvalid && out_en_s && from_rpn_kip_tx.tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK_TX;
                end
            end
            ST_LOCK_RX: begin
                rx_ready_s = out_en_s;
                if (from_rpn_kip_rx.tvalid && out_en_s && from_rpn_kip_rx.tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK_RX;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Payload mux of the granted source.
    always_comb begin
        mux_data_s = from_rpn_kip_tx.tdata;
        mux_keep_s = from_rpn_kip_tx.tkeep;
        mux_id_s   = from_rpn_kip_tx.tid;
        mux_dest_s = from_rpn_kip_tx.tdest;
        mux_user_s = from_rpn_kip_tx.tuser;
        mux_last_s = from_rpn_kip_tx.tlast;
        if (rx_acc_s) begin
            mux_data_s = from_rpn_kip_rx.tdata;
            mux_keep_s = from_rpn_kip_rx.tkeep;
            mux_id_s   = from_rpn_kip_rx.tid;
            mux_dest_s = from_rpn_kip_rx.tdest;
            mux_user_s = from_rpn_kip_rx.tuser;
            mux_last_s = from_rpn_kip_rx.tlast;
        end else begin
            mux_last_s = from_rpn_kip_tx.tlast;
        end
    end

    // Output register: loads when empty or draining, holds the beat while stalled.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_id_r    <= '0;
            out_dest_r  <= '0;
            out_user_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (out_en_s) begin
            out_valid_r <= tx_acc_s || rx_acc_s;
            if (tx_acc_s || rx_acc_s) begin
                out_data_r <= mux_data_s;
                out_keep_r <= mux_keep_s;
                out_id_r   <= mux_id_s;
                out_dest_r <= mux_dest_s;
                out_user_r <= mux_user_s;
                out_last_r <= mux_last_s;
            end
        end
    end

    // Per-source packet counters, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            tx_cnt_r <= '0;
            rx_cnt_r <= '0;
        end else begin
            if (tx_acc_s && from_rpn_kip_tx.tlast) begin
                tx_cnt_r <= tx_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (rx_acc_s && from_rpn_kip_rx.tlast) begin
                rx_cnt_r <= rx_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_rpn_kip_to_network_bridge_merger.sv
// Directed bench for the KIP-to-network-bridge merger: a vector table of packet
// scenarios plus hand-written reset, latency, mid-packet reset and counter-wrap sequences.
module tb_rpn_kip_to_network_bridge_merger;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 16;
    localparam int UW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc_cnt = 32'd0;
    logic [1:0]  ready_mode = 2'd0;

    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW)) tx_if ();
    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW)) rx_if ();
    rpn_kip_to_network_bridge_merger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW)) nb_if ();

    rpn_kip_to_network_bridge_merger #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TO_NB_TDEST_WIDTH(IW),
        .AXIS_TO_NB_TUSER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk),
        .i_ap_rst(rst),
        .from_rpn_kip_tx(tx_if),
        .from_rpn_kip_rx(rx_if),
        .to_network_bridge(nb_if),
        .o_tx_pkt_count(tx_cnt),
        .o_rx_pkt_count(rx_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

    localparam logic [IW-1:0] RX_ID   = 16'h0002;
    localparam logic [IW-1:0] RX_DEST = 16'h0B0B;
    localparam logic [UW-1:0] RX_USER = 16'h0077;
    localparam logic [KW-1:0] RX_KEEP = 8'hFF;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [15:0] id;
        logic [15:0] dest;
        logic [15:0] user;
        logic [7:0]  keep;
        logic [31:0] cyc;
    } beat_t;

    beat_t q[$];

    typedef struct packed {
        logic [2:0]       tx_n;
        logic [2:0]       rx_n;
        logic [3:0][63:0] tx_d;
        logic [3:0][63:0] rx_d;
        logic [15:0]      tx_id;
        logic [15:0]      tx_dest;
        logic [15:0]      tx_user;
        logic [7:0]       tx_keep;
        logic [1:0]       ready_mode;
        logic             consec;
        logic [3:0]       exp_n;
        logic [7:0][63:0] exp_d;
        logic [7:0]       exp_src;
        logic [7:0]       exp_last;
        logic [3:0]       exp_tx_cnt;
        logic [3:0]       exp_rx_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 stalled.
    initial begin
        nb_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                2'd1:    nb_if.tready = !nb_if.tready;
                2'd2:    nb_if.tready = 1'b0;
                default: nb_if.tready = 1'b1;
            endcase
        end
    end

    // Output monitor: collects accepted beats and checks payload stability while stalled.
    logic  stall_prev = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {63'd0, nb_if.tvalid}, 64'd1);
                check("stall_data", nb_if.tdata, held.d);
                check("stall_last", {63'd0, nb_if.tlast}, {63'd0, held.l});
            end
            stall_prev = nb_if.tvalid && !nb_if.tready;
            held.d = nb_if.tdata;
            held.l = nb_if.tlast;
            if (nb_if.tvalid && nb_if.tready) begin
                q.push_back('{d: nb_if.tdata, l: nb_if.tlast, id: nb_if.tid, dest: nb_if.tdest,
                              user: nb_if.tuser, keep: nb_if.tkeep, cyc: cyc_cnt});
            end
        end
    end

    task automatic wait_accept(input bit src, output bit ok);
        logic acc;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = src ? (rx_if.tvalid && rx_if.tready) : (tx_if.tvalid && tx_if.tready);
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive(input bit src, input logic v, input logic [63:0] d, input logic l);
        if (src) begin
            rx_if.tvalid = v; rx_if.tdata = d; rx_if.tlast = l;
        end else begin
            tx_if.tvalid = v; tx_if.tdata = d; tx_if.tlast = l;
        end
    endtask

    task automatic send_pkt(input bit src, input int n, input logic [3:0][63:0] d);
        bit ok;
        for (int i = 0; i < n; i++) begin
            drive(src, 1'b1, d[i], (i == n - 1));
            wait_accept(src, ok);
            if (!ok) begin
                check(src ? "rx_accept_timeout" : "tx_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        drive(src, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic wait_drain(input int n);
        for (int c = 0; c < 60 && q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0][63:0] pd;
        bit ok;

        vecs[0] = '0;
        vecs[0].tx_n = 3'd3;
        vecs[0].tx_d = {64'h0, 64'h33, 64'h22, 64'h11};
        vecs[0].tx_id = 16'h0001; vecs[0].tx_dest = 16'h0010; vecs[0].tx_user = 16'h0100; vecs[0].tx_keep = 8'hFF;
        vecs[0].consec = 1'b1;
        vecs[0].exp_n = 4'd3;
        vecs[0].exp_d = {{5{64'h0}}, 64'h33, 64'h22, 64'h11};
        vecs[0].exp_src = 8'b0000_0000; vecs[0].exp_last = 8'b0000_0100;
        vecs[0].exp_tx_cnt = 4'd1; vecs[0].exp_rx_cnt = 4'd0;

        vecs[1] = vecs[0];
        vecs[1].tx_n = 3'd0; vecs[1].rx_n = 3'd1; vecs[1].consec = 1'b0;
        vecs[1].rx_d = {{3{64'h0}}, 64'h5A};
        vecs[1].exp_n = 4'd1;
        vecs[1].exp_d = {{7{64'h0}}, 64'h5A};
        vecs[1].exp_src = 8'b0000_0001; vecs[1].exp_last = 8'b0000_0001;
        vecs[1].exp_tx_cnt = 4'd1; vecs[1].exp_rx_cnt = 4'd1;

        vecs[2] = vecs[1];
        vecs[2].tx_n = 3'd2; vecs[2].rx_n = 3'd2;
        vecs[2].tx_d = {64'h0, 64'h0, 64'hA2, 64'hA1};
        vecs[2].rx_d = {64'h0, 64'h0, 64'hB2, 64'hB1};
        vecs[2].exp_n = 4'd4;
        vecs[2].exp_d = {{4{64'h0}}, 64'hB2, 64'hB1, 64'hA2, 64'hA1};
        vecs[2].exp_src = 8'b0000_1100; vecs[2].exp_last = 8'b0000_1010;
        vecs[2].exp_tx_cnt = 4'd2; vecs[2].exp_rx_cnt = 4'd2;

        vecs[3] = vecs[2];
        vecs[3].tx_d = {64'h0, 64'h0, 64'hC2, 64'hC1};
        vecs[3].rx_d = {64'h0, 64'h0, 64'hD2, 64'hD1};
        vecs[3].exp_d = {{4{64'h0}}, 64'hD2, 64'hD1, 64'hC2, 64'hC1};
        vecs[3].exp_tx_cnt = 4'd3; vecs[3].exp_rx_cnt = 4'd3;

        vecs[4] = vecs[3];
        vecs[4].tx_n = 3'd0; vecs[4].rx_n = 3'd4; vecs[4].ready_mode = 2'd1;
        vecs[4].rx_d = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
        vecs[4].exp_d = {{4{64'h0}}, 64'hE4, 64'hE3, 64'hE2, 64'hE1};
        vecs[4].exp_src = 8'b0000_1111; vecs[4].exp_last = 8'b0000_1000;
        vecs[4].exp_tx_cnt = 4'd3; vecs[4].exp_rx_cnt = 4'd4;

        vecs[5] = vecs[0];
        vecs[5].tx_n = 3'd1;
        vecs[5].tx_d = {{3{64'h0}}, 64'hF00D};
        vecs[5].tx_id = 16'h0005; vecs[5].tx_dest = 16'hABCD; vecs[5].tx_user = 16'h1234; vecs[5].tx_keep = 8'h0F;
        vecs[5].exp_n = 4'd1;
        vecs[5].exp_d = {{7{64'h0}}, 64'hF00D};
        vecs[5].exp_src = 8'b0; vecs[5].exp_last = 8'b0000_0001;
        vecs[5].exp_tx_cnt = 4'd4; vecs[5].exp_rx_cnt = 4'd4;

        rx_if.tid = RX_ID; rx_if.tdest = RX_DEST; rx_if.tuser = RX_USER; rx_if.tkeep = RX_KEEP;
        tx_if.tid = 16'h0; tx_if.tdest = 16'h0; tx_if.tuser = 16'h0; tx_if.tkeep = 8'h0;

        // Reset with both sources requesting.
        rst = 1'b1;
        drive(1'b0, 1'b1, 64'hDEAD, 1'b1);
        drive(1'b1, 1'b1, 64'hBEEF, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", {63'd0, nb_if.tvalid}, 64'd0);
        check("rst_tdata", nb_if.tdata, 64'd0);
        check("rst_tx_ready", {63'd0, tx_if.tready}, 64'd0);
        check("rst_rx_ready", {63'd0, rx_if.tready}, 64'd0);
        check("rst_tx_cnt", {60'd0, tx_cnt}, 64'd0);
        check("rst_rx_cnt", {60'd0, rx_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_grant_tx_ready", {63'd0, tx_if.tready}, 64'd1);
        check("first_grant_rx_ready", {63'd0, rx_if.tready}, 64'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        drive(1'b1, 1'b0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        do_reset(1);
        q.delete();

        // Packet scenario table.
        for (int v = 0; v < 6; v++) begin
            tx_if.tid = vecs[v].tx_id; tx_if.tdest = vecs[v].tx_dest;
            tx_if.tuser = vecs[v].tx_user; tx_if.tkeep = vecs[v].tx_keep;
            ready_mode = vecs[v].ready_mode;
            fork
                begin
                    if (vecs[v].tx_n != 3'd0) send_pkt(1'b0, int'(vecs[v].tx_n), vecs[v].tx_d);
                end
                begin
                    if (vecs[v].rx_n != 3'd0) send_pkt(1'b1, int'(vecs[v].rx_n), vecs[v].rx_d);
                end
            join
            wait_drain(int'(vecs[v].exp_n));
            ready_mode = 2'd0;
            check($sformatf("v%0d_beats", v), 64'(q.size()), 64'(vecs[v].exp_n));
            for (int i = 0; i < int'(vecs[v].exp_n) && i < q.size(); i++) begin
                check($sformatf("v%0d_b%0d_data", v, i), q[i].d, vecs[v].exp_d[i]);
                check($sformatf("v%0d_b%0d_last", v, i), {63'd0, q[i].l}, {63'd0, vecs[v].exp_last[i]});
                check($sformatf("v%0d_b%0d_tid", v, i), {48'd0, q[i].id},
                      {48'd0, vecs[v].exp_src[i] ? RX_ID : vecs[v].tx_id});
                check($sformatf("v%0d_b%0d_tdest", v, i), {48'd0, q[i].dest},
                      {48'd0, vecs[v].exp_src[i] ? RX_DEST : vecs[v].tx_dest});
                check($sformatf("v%0d_b%0d_tuser", v, i), {48'd0, q[i].user},
                      {48'd0, vecs[v].exp_src[i] ? RX_USER : vecs[v].tx_user});
                check($sformatf("v%0d_b%0d_tkeep", v, i), {56'd0, q[i].keep},
                      {56'd0, vecs[v].exp_src[i] ? RX_KEEP : vecs[v].tx_keep});
                if (vecs[v].consec && i > 0) begin
                    check($sformatf("v%0d_b%0d_consec", v, i), 64'(q[i].cyc - q[i-1].cyc), 64'd1);
                end
            end
            check($sformatf("v%0d_tx_cnt", v), {60'd0, tx_cnt}, {60'd0, vecs[v].exp_tx_cnt});
            check($sformatf("v%0d_rx_cnt", v), {60'd0, rx_cnt}, {60'd0, vecs[v].exp_rx_cnt});
            q.delete();
        end

        // One arbitration cycle, then latency 1 from acceptance to output.
        drive(1'b0, 1'b1, 64'h77, 1'b1);
        @(negedge clk);
        check("lat_idle_tx_ready", {63'd0, tx_if.tready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_lock_tx_ready", {63'd0, tx_if.tready}, 64'd1);
        check("lat_out_empty", {63'd0, nb_if.tvalid}, 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        check("lat_out_valid", {63'd0, nb_if.tvalid}, 64'd1);
        check("lat_out_data", nb_if.tdata, 64'h77);
        check("lat_out_last", {63'd0, nb_if.tlast}, 64'd1);
        check("lat_tx_cnt", {60'd0, tx_cnt}, 64'd5);
        @(negedge clk);
        check("lat_out_drained", {63'd0, nb_if.tvalid}, 64'd0);
        @(posedge clk);
        #1;
        q.delete();

        // Reset after two beats of a four-beat packet.
        pd = {64'h44, 64'h43, 64'h42, 64'h41};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, pd[i], 1'b0);
            wait_accept(1'b0, ok);
            check($sformatf("mid_accept_%0d", i), {63'd0, ok}, 64'd1);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tvalid", {63'd0, nb_if.tvalid}, 64'd0);
        check("mid_rst_tx_ready", {63'd0, tx_if.tready}, 64'd0);
        check("mid_rst_tx_cnt", {60'd0, tx_cnt}, 64'd0);
        @(posedge clk);
        #1;
        q.delete();
        send_pkt(1'b0, 2, {64'h0, 64'h0, 64'h62, 64'h61});
        wait_drain(2);
        check("post_rst_beats", 64'(q.size()), 64'd2);
        if (q.size() >= 2) begin
            check("post_rst_b0", q[0].d, 64'h61);
            check("post_rst_b1", q[1].d, 64'h62);
            check("post_rst_b1_last", {63'd0, q[1].l}, 64'd1);
        end
        check("post_rst_tx_cnt", {60'd0, tx_cnt}, 64'd1);
        q.delete();

        // Counter wrap at 2^CNT_WIDTH.
        do_reset(2);
        for (int p = 0; p < 17; p++) begin
            send_pkt(1'b0, 1, {64'h0, 64'h0, 64'h0, 64'(p)});
        end
        wait_drain(17);
        check("wrap_beats", 64'(q.size()), 64'd17);
        check("wrap_tx_cnt", {60'd0, tx_cnt}, 64'd1);
        check("wrap_rx_cnt", {60'd0, rx_cnt}, 64'd0);
        q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
